regfile_scoreboard: RTL and testbench

- Integer register file and busy scoreboard at the far end of the writeback interface.
- Consumes the writeback stage's one-cycle write pulse (valid, reg_w, rd, 64-bit data) and commits it to x1..x31.
- Serves two combinational read ports to decode.
- Tracks in-flight destination registers so decode can stall on read-after-write hazards.

---
 rtl/regfile_scoreboard.sv | 127 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Integer register file (x1..x31) with a busy scoreboard. It sits at the far
// end of the writeback interface: each one-cycle writeback pulse commits its
// data to the register file and retires the destination's busy bit. Decode
// reads two operands combinationally and stalls on `hazard` while an operand
// still has an in-flight producer.
//
// Build option: define REGFILE_BYPASS_EN to enable write-through. A read whose
// index matches the register being written this cycle then returns the
// writeback data in the same cycle, and that register's busy bit is treated
// as already cleared for the hazard. Without the macro, reads return only
// stored values and the hazard persists through the writeback cycle.
//
// Ports:
//   clk                  in   clock, rising edge
//   rst                  in   asynchronous active-low reset; clears all state
//   writeback_valid      in   one-cycle write pulse from writeback
//   reg_writeback_reg_w  in   retiring instruction writes a register
//   reg_writeback_rd     in   retiring destination index
//   reg_writeback_data   in   write data
//   issue_valid          in   decode issues an instruction this cycle
//   issue_reg_w          in   issued instruction writes a register
//   issue_rd             in   issued destination index
//   flush                in   clears every busy bit
//   rs1_addr, rs2_addr   in   read port indices
//   rs1_data, rs2_data   out  read port data (x0 reads as 0)
//   hazard               out  an operand has a pending producer
//   busy_vec             out  busy bits, bit i = xi (bit 0 always 0)
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            writeback_valid,
  input  logic            reg_writeback_reg_w,
  input  logic [4:0]      reg_writeback_rd,
  input  logic [XLEN-1:0] reg_writeback_data,
  input  logic            issue_valid,
  input  logic            issue_reg_w,
  input  logic [4:0]      issue_rd,
  input  logic            flush,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            hazard,
  output logic [NREG-1:0] busy_vec
);

  logic            we;
  logic            issue_we;
  logic [XLEN-1:0] regs_view [NREG];
  logic            clr_rs1;
  logic            clr_rs2;

  // x0 is excluded from the write enable so it can never be written or cleared.
  assign we       = writeback_valid & reg_writeback_reg_w & (reg_writeback_rd != 5'd0);
  assign issue_we = issue_valid & issue_reg_w;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_x0
        // x0 is hardwired: no storage, never busy.
        assign regs_view[gi] = '0;
        assign busy_vec[gi]  = 1'b0;
      end else begin : g_xn
        logic            set_w;
        logic            clr_w;
        logic [XLEN-1:0] reg_q;
        logic [XLEN-1:0] reg_d;
        logic            busy_q;
        logic            busy_d;

        assign set_w = issue_we & (issue_rd == 5'(gi));
        assign clr_w = we & (reg_writeback_rd == 5'(gi));
        assign reg_d = clr_w ? reg_writeback_data : reg_q;
        // A new producer issued in the same cycle supersedes the retiring one,
        // so set beats clear; flush beats both.
        assign busy_d = flush ? 1'b0 : (set_w | (busy_q & ~clr_w));

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            reg_q  <= '0;
            busy_q <= 1'b0;
          end else begin
            reg_q  <= reg_d;
            busy_q <= busy_d;
          end
        end

        assign regs_view[gi] = reg_q;
        assign busy_vec[gi]  = busy_q;
      end
    end
  endgenerate

  always_comb begin
    rs1_data = regs_view[rs1_addr];
    rs2_data = regs_view[rs2_addr];
    clr_rs1  = 1'b0;
    clr_rs2  = 1'b0;
`ifdef REGFILE_BYPASS_EN
    // Write-through: `we` is never high for index 0, so x0 stays 0.
    if (we && (reg_writeback_rd == rs1_addr)) begin
      rs1_data = reg_writeback_data;
      clr_rs1  = 1'b1;
    end
    if (we && (reg_writeback_rd == rs2_addr)) begin
      rs2_data = reg_writeback_data;
      clr_rs2  = 1'b1;
    end
`endif
    hazard = (busy_vec[rs1_addr] & ~clr_rs1) | (busy_vec[rs2_addr] & ~clr_rs2);
    // While reset is held the bypass path must not leak writeback data.
    if (!rst) begin
      rs1_data = '0;
      rs2_data = '0;
      hazard   = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Drives directed scenarios and a randomized phase into regfile_scoreboard.
// A behavioural model (plain register/busy arrays updated by the architectural
// rules) predicts the outputs, and a negedge compare process checks them on
// every cycle. Directed scenarios also carry literal expectations.
// Define REGFILE_BYPASS_EN for both the bench and the RTL to test write-through.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        writeback_valid;
  logic        reg_writeback_reg_w;
  logic [4:0]  reg_writeback_rd;
  logic [63:0] reg_writeback_data;
  logic        issue_valid;
  logic        issue_reg_w;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        hazard;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state.
  logic [63:0] m_regs [32];
  bit          m_busy [32];

  regfile_scoreboard #(.NREG(32), .XLEN(64)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .writeback_valid     (writeback_valid),
    .reg_writeback_reg_w (reg_writeback_reg_w),
    .reg_writeback_rd    (reg_writeback_rd),
    .reg_writeback_data  (reg_writeback_data),
    .issue_valid         (issue_valid),
    .issue_reg_w         (issue_reg_w),
    .issue_rd            (issue_rd),
    .flush               (flush),
    .rs1_addr            (rs1_addr),
    .rs2_addr            (rs2_addr),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .hazard              (hazard),
    .busy_vec            (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_we();
    return writeback_valid && reg_writeback_reg_w && (reg_writeback_rd != 5'd0);
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (!rst || a == 5'd0) return 64'd0;
    if (BYPASS && m_we() && reg_writeback_rd == a) return reg_writeback_data;
    return m_regs[a];
  endfunction

  function automatic bit m_pending(input logic [4:0] a);
    if (!rst || a == 5'd0) return 1'b0;
    if (BYPASS && m_we() && reg_writeback_rd == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] m_busyvec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Model state: cleared asynchronously, updated on each rising edge.
  always @(negedge rst) begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 64'd0;
      m_busy[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (m_we()) m_regs[reg_writeback_rd] = reg_writeback_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (m_we()) m_busy[reg_writeback_rd] = 1'b0;
        if (issue_valid && issue_reg_w && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  bit check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      chk("rs1_data", rs1_data, m_read(rs1_addr));
      chk("rs2_data", rs2_data, m_read(rs2_addr));
      chk("hazard", {63'd0, hazard}, {63'd0, m_pending(rs1_addr) | m_pending(rs2_addr)});
      chk("busy_vec", {32'd0, busy_vec}, {32'd0, m_busyvec()});
    end
  end

  task automatic idle();
    writeback_valid     = 1'b0;
    reg_writeback_reg_w = 1'b0;
    reg_writeback_rd    = 5'd0;
    reg_writeback_data  = 64'd0;
    issue_valid         = 1'b0;
    issue_reg_w         = 1'b0;
    issue_rd            = 5'd0;
    flush               = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [63:0] data, input logic regw);
    writeback_valid     = 1'b1;
    reg_writeback_reg_w = regw;
    reg_writeback_rd    = rd;
    reg_writeback_data  = data;
  endtask

  task automatic iss(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_reg_w = 1'b1;
    issue_rd    = rd;
  endtask

  function automatic logic [4:0] rand_idx();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 64'd0;
      m_busy[i] = 1'b0;
    end
    rst = 1'b0;
    idle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    check_en = 1'b1;
    repeat (3) step();

    // Reset state after release.
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rs1", rs1_data, 64'd0);
    chk("rst_rs2", rs2_data, 64'd0);
    chk("rst_hazard", {63'd0, hazard}, 64'd0);
    chk("rst_busy", {32'd0, busy_vec}, 64'd0);

    // Write x3 and read it back through port 1.
    step();
    wb(5'd3, 64'hDEADBEEF, 1'b1);
    rs1_addr = 5'd3;
    @(negedge clk);
    chk("x3_pulse", rs1_data, BYPASS ? 64'hDEADBEEF : 64'd0);
    step();
    idle();
    @(negedge clk);
    chk("x3_after", rs1_data, 64'hDEADBEEF);

    // x0 write is dropped; reg_w=0 pulse does not write x4.
    step();
    wb(5'd0, 64'h1234, 1'b1);
    step();
    wb(5'd4, 64'h5555, 1'b0);
    step();
    idle();
    rs1_addr = 5'd0;
    rs2_addr = 5'd4;
    @(negedge clk);
    chk("x0_zero", rs1_data, 64'd0);
    chk("x4_kept", rs2_data, 64'd0);

    // Issue x7, hazard until its writeback.
    step();
    iss(5'd7);
    rs1_addr = 5'd3;
    rs2_addr = 5'd7;
    @(negedge clk);
    chk("x7_issue_cycle_hz", {63'd0, hazard}, 64'd0);
    step();
    idle();
    @(negedge clk);
    chk("x7_busy_hz", {63'd0, hazard}, 64'd1);
    chk("x7_busy_bit", {63'd0, busy_vec[7]}, 64'd1);
    step();
    wb(5'd7, 64'h77, 1'b1);
    @(negedge clk);
    chk("x7_wb_hz", {63'd0, hazard}, BYPASS ? 64'd0 : 64'd1);
    step();
    idle();
    @(negedge clk);
    chk("x7_done_hz", {63'd0, hazard}, 64'd0);
    chk("x7_done_bit", {63'd0, busy_vec[7]}, 64'd0);

    // Same-cycle issue and writeback of x9: busy survives, data updates.
    step();
    iss(5'd9);
    wb(5'd9, 64'h99, 1'b1);
    step();
    idle();
    rs1_addr = 5'd9;
    @(negedge clk);
    chk("x9_busy_kept", {63'd0, busy_vec[9]}, 64'd1);
    chk("x9_data", rs1_data, 64'h99);
    step();
    flush = 1'b1;
    step();
    idle();
    @(negedge clk);
    chk("flush_busy", {32'd0, busy_vec}, 64'd0);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      step();
      writeback_valid     = ($urandom_range(0, 1) == 1);
      reg_writeback_reg_w = ($urandom_range(0, 3) != 0);
      reg_writeback_rd    = rand_idx();
      reg_writeback_data  = {$urandom, $urandom};
      issue_valid         = ($urandom_range(0, 1) == 1);
      issue_reg_w         = ($urandom_range(0, 3) != 0);
      issue_rd            = rand_idx();
      flush               = ($urandom_range(0, 31) == 0);
      rs1_addr            = rand_idx();
      rs2_addr            = rand_idx();
    end

    // Fill x1..x31 with i*0x11, leave x12 busy, then reset mid-cycle.
    for (int i = 1; i < 32; i++) begin
      step();
      idle();
      wb(5'(i), 64'(i * 17), 1'b1);
    end
    iss(5'd12);
    step();
    idle();
    rs1_addr = 5'd31;
    rs2_addr = 5'd12;
    @(negedge clk);
    chk("fill_x31", rs1_data, 64'h20F);
    chk("fill_x12", rs2_data, 64'hCC);
    chk("fill_hz", {63'd0, hazard}, 64'd1);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rs1", rs1_data, 64'd0);
    chk("async_rs2", rs2_data, 64'd0);
    chk("async_hz", {63'd0, hazard}, 64'd0);
    chk("async_busy", {32'd0, busy_vec}, 64'd0);
    step();
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("post_rst_x31", rs1_data, 64'd0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
